// File: rtl/rom_prefetch.sv
// Instruction prefetcher: issues sequential word reads to the ROM, buffers the
// returned words with their PCs in a small FIFO, and supports redirect/flush.
module rom_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        rom_valid,
    output logic        rom_instr,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_rdata,
    input  logic        rom_ready,
    input  logic        fetch_flush,
    input  logic [31:0] fetch_target,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr,
    input  logic        fetch_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW+1:0] L_DEPTH = (AW+2)'(DEPTH);

    logic [AW:0]   r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic          r_rom_valid;
    logic          r_outstanding;
    logic          r_drop;

    logic          w_resp;
    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic [AW+1:0] w_occupancy;
    logic [31:0]   w_entry_pc    [DEPTH];
    logic [31:0]   w_entry_instr [DEPTH];

    assign w_resp  = rom_ready & r_outstanding;
    assign w_push  = w_resp & ~r_drop & ~fetch_flush;
    assign w_pop   = (r_count != '0) & fetch_ready & ~fetch_flush;

    // The outstanding request reserves its slot, so a response never finds the FIFO full.
    assign w_occupancy = {1'b0, r_count} + {{(AW+1){1'b0}}, r_outstanding};
    assign w_issue     = ~fetch_flush & (~r_outstanding | rom_ready) & (w_occupancy < L_DEPTH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rom_valid   <= 1'b0;
            r_req_pc      <= RESET_PC;
            r_pc          <= RESET_PC;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            r_rom_valid <= w_issue;
            if (fetch_flush) begin
                r_pc <= fetch_target & 32'hFFFF_FFFC;
            end else if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_issue) begin
                r_req_pc <= r_pc;
            end
            if (w_issue) begin
                r_outstanding <= 1'b1;
            end else if (w_resp) begin
                r_outstanding <= 1'b0;
            end
            // A flush orphans a request still in flight; its eventual response is swallowed.
            if (fetch_flush) begin
                r_drop <= r_outstanding & ~rom_ready;
            end else if (w_resp) begin
                r_drop <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (fetch_flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [31:0] r_e_pc;
        logic [31:0] r_e_instr;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_e_pc    <= '0;
                r_e_instr <= '0;
            end else if (w_push && (r_wr_ptr == AW'(gi))) begin
                r_e_pc    <= r_req_pc;
                r_e_instr <= rom_rdata;
            end
        end

        assign w_entry_pc[gi]    = r_e_pc;
        assign w_entry_instr[gi] = r_e_instr;
    end

    assign rom_valid   = r_rom_valid;
    assign rom_instr   = 1'b1;
    assign rom_addr    = r_req_pc;
    assign fetch_valid = (r_count != '0);
    assign fetch_pc    = w_entry_pc[r_rd_ptr];
    assign fetch_instr = w_entry_instr[r_rd_ptr];

endmodule

// File: tb/tb_rom_prefetch.sv
// Bench for rom_prefetch: modelled ROM responder with programmable latency,
// scoreboard of expected fetch words, cycle tables plus hand-written corner cases.
module tb_rom_prefetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rom_valid;
    logic        rom_instr;
    logic [31:0] rom_addr;
    logic [31:0] rom_rdata = '0;
    logic        rom_ready = 1'b0;
    logic        fetch_flush = 1'b0;
    logic [31:0] fetch_target = '0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_ready = 1'b0;

    rom_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock        (clock),
        .reset        (reset),
        .rom_valid    (rom_valid),
        .rom_instr    (rom_instr),
        .rom_addr     (rom_addr),
        .rom_rdata    (rom_rdata),
        .rom_ready    (rom_ready),
        .fetch_flush  (fetch_flush),
        .fetch_target (fetch_target),
        .fetch_valid  (fetch_valid),
        .fetch_pc     (fetch_pc),
        .fetch_instr  (fetch_instr),
        .fetch_ready  (fetch_ready)
    );

    always #5 clock = ~clock;

    int          n_assert  = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          lat       = 1;
    int          resp_wait = -1;
    int          gen       = 0;
    int          p_gen     = 0;
    logic [31:0] p_addr    = '0;
    logic [63:0] sb [$];
    logic [31:0] issue_log [$];
    logic [31:0] pop_log [$];

    typedef struct {
        logic        start;
        logic        fr;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_fv;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h4101_4081;
            32'h0000_0004: return 32'h4201_4181;
            32'h0000_0008: return 32'h4301_4281;
            default:       return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        issue_log.delete();
        pop_log.delete();
        resp_wait = -1;
        gen++;
        lat = 1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        rom_ready = 1'b0;
        rom_rdata = '0;
        fetch_flush = 1'b0;
        fetch_target = '0;
        fetch_ready = 1'b0;
        clear_model();
        #1;
        chk("rst_rom_valid", rom_valid, 0);
        chk("rst_rom_addr", rom_addr, 32'h0);
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_fetch_pc", fetch_pc, 0);
        chk("rst_fetch_instr", fetch_instr, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        cyc = 0;
    endtask

    // One clock cycle: drive inputs and responder after the edge, check and score at the falling edge.
    task automatic step(input logic fr, input logic fl, input logic [31:0] tgt);
        logic        delivered;
        logic [63:0] e;
        @(posedge clock);
        #1;
        cyc++;
        fetch_ready  = fr;
        fetch_flush  = fl;
        fetch_target = tgt;
        rom_ready    = 1'b0;
        delivered    = 1'b0;
        if (rom_valid) begin
            chk("single_outstanding", (resp_wait >= 0) ? 32'd1 : 32'd0, 32'd0);
            p_addr    = rom_addr;
            p_gen     = gen;
            resp_wait = lat - 1;
            issue_log.push_back(rom_addr);
            $display("cyc %0d request addr=%h", cyc, rom_addr);
        end
        if (resp_wait == 0) begin
            rom_ready = 1'b1;
            rom_rdata = memf(p_addr);
            resp_wait = -1;
            delivered = 1'b1;
        end else if (resp_wait > 0) begin
            resp_wait--;
        end
        @(negedge clock);
        chk("fetch_valid", fetch_valid, (sb.size() != 0) ? 32'd1 : 32'd0);
        if (fetch_valid && sb.size() != 0) begin
            e = sb[0];
            chk("fetch_pc", fetch_pc, e[63:32]);
            chk("fetch_instr", fetch_instr, e[31:0]);
            if (fr) begin
                void'(sb.pop_front());
                pop_log.push_back(fetch_pc);
                $display("cyc %0d fetch pc=%h instr=%h", cyc, fetch_pc, fetch_instr);
            end
        end
        if (delivered && p_gen == gen && !fl) begin
            sb.push_back({p_addr, memf(p_addr)});
        end
        if (fl) begin
            sb.delete();
            gen++;
        end
    endtask

    initial begin
        int base;

        // Rows 0-4: streaming with fetch_ready=1; rows 5-12: fetch_ready=0 fills the FIFO.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00, memf(32'h00)};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04, memf(32'h04)};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08, memf(32'h08)};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C, memf(32'h0C)};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00, memf(32'h00)};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00, memf(32'h00)};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00, memf(32'h00)};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00, memf(32'h00)};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00, memf(32'h00)};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00, memf(32'h00)};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00, memf(32'h00)};

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].start) do_reset();
            if (i == 0) chk("rom_instr_const", rom_instr, 1);
            step(vecs[i].fr, 1'b0, 32'h0);
            chk("tbl_rom_valid", rom_valid, vecs[i].exp_rv);
            if (vecs[i].exp_rv) chk("tbl_rom_addr", rom_addr, vecs[i].exp_addr);
            chk("tbl_fetch_valid", fetch_valid, vecs[i].exp_fv);
            if (vecs[i].exp_fv) begin
                chk("tbl_fetch_pc", fetch_pc, vecs[i].exp_pc);
                chk("tbl_fetch_instr", fetch_instr, vecs[i].exp_instr);
            end
        end

        // Full FIFO: a single pop frees exactly one slot for one new request.
        base = issue_log.size();
        step(1'b1, 1'b0, 32'h0);
        repeat (5) step(1'b0, 1'b0, 32'h0);
        chk("full_one_more_issue", issue_log.size() - base, 1);
        if (issue_log.size() > base) chk("full_next_addr", issue_log[base], 32'h10);
        chk("full_rom_valid_idle", rom_valid, 0);

        // Flush coincident with the response to 0x08.
        do_reset();
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h40);
        chk("flush_resp_addr", rom_addr, 32'h08);
        chk("flush_resp_ready", rom_ready, 1);
        step(1'b1, 1'b0, 32'h0);
        chk("flush_fv_next", fetch_valid, 0);
        chk("flush_rv_next", rom_valid, 0);
        step(1'b1, 1'b0, 32'h0);
        chk("flush_new_rv", rom_valid, 1);
        chk("flush_new_addr", rom_addr, 32'h40);
        step(1'b1, 1'b0, 32'h0);
        chk("flush_first_fv", fetch_valid, 1);
        chk("flush_first_pc", fetch_pc, 32'h40);
        repeat (3) step(1'b1, 1'b0, 32'h0);

        // Flush to an unaligned target while a 3-cycle response is in flight.
        do_reset();
        lat = 3;
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h23);
        chk("drop_rv_flush", rom_valid, 0);
        step(1'b1, 1'b0, 32'h0);
        chk("drop_ready_arrives", rom_ready, 1);
        chk("drop_rv_wait", rom_valid, 0);
        step(1'b1, 1'b0, 32'h0);
        chk("drop_new_rv", rom_valid, 1);
        chk("drop_new_addr", rom_addr, 32'h20);
        repeat (8) step(1'b1, 1'b0, 32'h0);
        if (pop_log.size() > 0) chk("drop_first_pop", pop_log[0], 32'h20);
        else chk("drop_pop_count", pop_log.size(), 1);

        // Address wrap at the top of the 32-bit space.
        do_reset();
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        base = issue_log.size();
        repeat (6) step(1'b1, 1'b0, 32'h0);
        chk("wrap_issue_count_ge3", (issue_log.size() - base >= 3) ? 32'd1 : 32'd0, 32'd1);
        if (issue_log.size() - base >= 3) begin
            chk("wrap_addr0", issue_log[base],     32'hFFFF_FFF8);
            chk("wrap_addr1", issue_log[base + 1], 32'hFFFF_FFFC);
            chk("wrap_addr2", issue_log[base + 2], 32'h0000_0000);
        end

        // Reset with two buffered entries and one outstanding; stale response after release.
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        lat = 100;
        step(1'b0, 1'b0, 32'h0);
        chk("midrst_pre_fv", fetch_valid, 1);
        reset = 1'b0;
        #1;
        chk("midrst_fv", fetch_valid, 0);
        chk("midrst_rv", rom_valid, 0);
        chk("midrst_pc", fetch_pc, 0);
        clear_model();
        fetch_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        rom_ready = 1'b1;
        rom_rdata = 32'hDEAD_BEEF;
        fetch_ready = 1'b1;
        cyc = 0;
        @(negedge clock);
        chk("stale_fv", fetch_valid, 0);
        step(1'b1, 1'b0, 32'h0);
        chk("stale_rv", rom_valid, 1);
        chk("stale_addr", rom_addr, 32'h0);
        chk("stale_fv_c1", fetch_valid, 0);
        step(1'b1, 1'b0, 32'h0);
        chk("restart_fv", fetch_valid, 1);
        chk("restart_pc", fetch_pc, 32'h0);
        chk("restart_instr", fetch_instr, 32'h4101_4081);
        repeat (3) step(1'b1, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
